// File: rtl/lza_pkg.sv
// Shared LZA constants, count-width helper and the stage-1 payload type.
package lza_pkg;

  localparam int unsigned LZA_DATA_WIDTH = 8;
  localparam int unsigned LZA_GROUP_W    = 4;
  localparam int unsigned LZA_NG         = LZA_DATA_WIDTH / LZA_GROUP_W;
  localparam int unsigned LZA_LZG_W      = $clog2(LZA_GROUP_W);

  // Width that can hold 0..width inclusive, so an all-zero string still fits.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned LZA_CNT_W = cnt_width(LZA_DATA_WIDTH);

  typedef struct packed {
    logic [LZA_NG-1:0]                nz;
    logic [LZA_NG-1:0][LZA_LZG_W-1:0] lzg;
  } s1_payload_t;

endpackage

// File: rtl/lzc_group.sv
// Combinational leading-zero counter for one group of the indicator string.
module lzc_group #(
  parameter int unsigned GROUP_W = 4
) (
  input  logic [GROUP_W-1:0]         bits,
  output logic                       nz,
  output logic [$clog2(GROUP_W)-1:0] lzg
);

  logic found;

  assign nz = |bits;

  // lzg is zero for an all-zero group; stage 2 never selects such a group.
  always_comb begin
    lzg   = '0;
    found = 1'b0;
    for (int i = GROUP_W - 1; i >= 0; i--) begin
      if (!found && bits[i]) begin
        lzg   = $clog2(GROUP_W)'(GROUP_W - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lza_lzc_pipe.sv
// Two-stage leading-zero counter over the LZA indicator string with valid/ready
// flow control: stage 1 registers per-group results, stage 2 the final count.
module lza_lzc_pipe
  import lza_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH = LZA_DATA_WIDTH,
  parameter int unsigned  GROUP_W    = LZA_GROUP_W,
  localparam int unsigned CNT_W      = cnt_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] string_f,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      lz_count,
  output logic                  all_zero
);

  localparam int unsigned NG    = DATA_WIDTH / GROUP_W;
  localparam int unsigned LZG_W = $clog2(GROUP_W);

  logic [NG-1:0]            grp_nz;
  logic [NG-1:0][LZG_W-1:0] grp_lzg;

  logic                     s1_valid_q;
  logic [NG-1:0]            s1_nz_q;
  logic [NG-1:0][LZG_W-1:0] s1_lzg_q;

  logic                     out_valid_q;
  logic [CNT_W-1:0]         lz_count_q;
  logic                     all_zero_q;

  logic                     s2_ready;
  logic                     s1_load;
  logic                     s2_load;
  logic [CNT_W-1:0]         cnt_d;
  logic                     all_zero_d;

  // Group 0 is the most significant group.
  for (genvar g = 0; g < NG; g++) begin : g_grp
    lzc_group #(
      .GROUP_W(GROUP_W)
    ) u_grp (
      .bits(string_f[DATA_WIDTH-1-g*GROUP_W -: GROUP_W]),
      .nz  (grp_nz[g]),
      .lzg (grp_lzg[g])
    );
  end

  assign s2_ready = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s2_ready;

  // Scan from the LSB group upward so the most significant set group wins.
  always_comb begin
    cnt_d      = CNT_W'(DATA_WIDTH);
    all_zero_d = 1'b1;
    for (int g = NG - 1; g >= 0; g--) begin
      if (s1_nz_q[g]) begin
        cnt_d      = CNT_W'(g * GROUP_W) + CNT_W'(s1_lzg_q[g]);
        all_zero_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_nz_q     <= '0;
      s1_lzg_q    <= '0;
      out_valid_q <= 1'b0;
      lz_count_q  <= '0;
      all_zero_q  <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid_q  <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        if (in_ready) s1_valid_q  <= in_valid;
        if (s2_ready) out_valid_q <= s1_valid_q;
      end
      if (s1_load) begin
        s1_nz_q  <= grp_nz;
        s1_lzg_q <= grp_lzg;
      end
      if (s2_load) begin
        lz_count_q <= cnt_d;
        all_zero_q <= all_zero_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign lz_count  = lz_count_q;
  assign all_zero  = all_zero_q;

endmodule

// File: tb/tb_lza_lzc_pipe.sv
// Scoreboard bench for lza_lzc_pipe at DATA_WIDTH=8, GROUP_W=4.
module tb_lza_lzc_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] string_f = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] lz_count;
  logic       all_zero;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [4:0] exp_q[$];

  lza_lzc_pipe #(
    .DATA_WIDTH(8),
    .GROUP_W   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .string_f (string_f),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .lz_count (lz_count),
    .all_zero (all_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Independent bit-scan reference: {all_zero, lz_count}.
  function automatic logic [4:0] ref_lz(input logic [7:0] v);
    int n;
    n = 8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        n = 7 - i;
        break;
      end
    end
    return {(n == 8), 4'(n)};
  endfunction

  // Present v until accepted; expected result is queued at the accepting edge.
  task automatic send(input logic [7:0] v, input logic [4:0] e, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    string_f = v;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        if (!flush) exp_q.push_back(e);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      waits++;
      if (waits > 50) begin
        chk("send_timeout", waits, 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // Monitor: an output transfer completes at the next rising edge.
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("result", {all_zero, lz_count}, e);
        end
      end
    end
  end

  initial begin
    int w;
    int total;
    logic [7:0] vals[16];
    vals = '{8'h16, 8'hFF, 8'h00, 8'h01, 8'h80, 8'h3C, 8'h0A, 8'h07,
             8'h40, 8'h10, 8'h08, 8'h02, 8'hC3, 8'h0F, 8'h20, 8'h04};

    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lz_count", lz_count, 0);
    chk("rst_all_zero", all_zero, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_in_ready", in_ready, 1);

    // Basic counts and group boundary, with a latency check on the first.
    send(8'h16, {1'b0, 4'd3}, w);
    chk("lat_basic_early", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_basic_valid", out_valid, 1);
    chk("lat_basic_count", lz_count, 3);
    send(8'h80, {1'b0, 4'd0}, w);
    send(8'h01, {1'b0, 4'd7}, w);
    send(8'h00, {1'b1, 4'd8}, w);
    send(8'h0F, {1'b0, 4'd4}, w);
    wait_drain();

    // Streaming: no input stalls, results one per cycle.
    total = 0;
    for (int i = 0; i < 16; i++) begin
      send(vals[i], ref_lz(vals[i]), w);
      total += w;
    end
    chk("stream_stalls", total, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("stream_throughput", exp_q.size(), 0);
    wait_drain();

    // Backpressure: both stages fill and the output holds.
    out_ready = 1'b0;
    send(8'h20, {1'b0, 4'd2}, w);
    send(8'h04, {1'b0, 4'd5}, w);
    in_valid = 1'b1;
    string_f = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_lz_held", lz_count, 2);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'h00, {1'b1, 4'd8}, w);
    wait_drain();

    // Flush with both stages full and an input offered.
    out_ready = 1'b0;
    send(8'h40, {1'b0, 4'd1}, w);
    send(8'h02, {1'b0, 4'd6}, w);
    chk("pre_flush_full", out_valid, 1);
    in_valid = 1'b1;
    string_f = 8'hFF;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_s1_empty", in_ready, 1);
    out_ready = 1'b1;
    send(8'h10, {1'b0, 4'd3}, w);
    chk("lat_flush_early", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_flush_valid", out_valid, 1);
    chk("lat_flush_count", lz_count, 3);
    wait_drain();

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(8'h08, {1'b0, 4'd4}, w);
    send(8'h03, {1'b0, 4'd6}, w);
    chk("pre_rst_count", lz_count, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_lz_count", lz_count, 0);
    chk("arst_in_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'h01, {1'b0, 4'd7}, w);
    chk("lat_rst_early", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_rst_valid", out_valid, 1);
    chk("lat_rst_count", lz_count, 7);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
